// File: rtl/mips_pkg.sv
// mips_pkg: access size codes, LSU state encoding and alignment check shared by the load/store unit
package mips_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_MERGE_WR, ST_RESP} lsu_state_t;
    // size 11 has no legal encoding, so it is reported like a misalignment
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00) || size == 2'b11;
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response bus from execute stage plus word-indexed data memory port
//   slave  : LSU side (takes requests, drives responses and memory A/WD/WE, reads RD)
//   master : execute stage / memory model side
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_misaligned;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic [31:0]       mem_rd;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_a, mem_wd, mem_we
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane select/extend for loads and lane merge for sub-word stores
//   i_size, i_unsigned, i_addr_lo : latched access attributes
//   i_rd, i_wdata                 : memory read word, store data (low bits)
//   o_load, o_merged              : extended load value, read word with new lane inserted
module lsu_byte_lane
    import mips_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_rep;
    assign w_bsh  = {i_addr_lo, 3'b000};
    assign w_hsh  = {i_addr_lo[1], 4'b0000};
    assign w_byte = 8'(i_rd >> w_bsh);
    assign w_half = 16'(i_rd >> w_hsh);
    assign o_load = (i_size == SZ_BYTE) ? {{24{~i_unsigned & w_byte[7]}}, w_byte} :
                    (i_size == SZ_HALF) ? {{16{~i_unsigned & w_half[15]}}, w_half} : i_rd;
    // replicating the store data across lanes lets one mask pick the target lane
    assign w_mask = (i_size == SZ_BYTE) ? (32'h0000_00FF << w_bsh) :
                    (i_size == SZ_HALF) ? (32'h0000_FFFF << w_hsh) : 32'hFFFF_FFFF;
    assign w_rep  = (i_size == SZ_BYTE) ? {4{i_wdata[7:0]}} :
                    (i_size == SZ_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
    assign o_merged = (i_rd & ~w_mask) | (w_rep & w_mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS load/store initiator, one request at a time, sub-word stores by read-modify-write
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request/response handshake and data memory port (slave view)
module load_store_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    if (DATA_W != 32) begin : g_bad_width
        $error("load_store_unit: DATA_W must be 32");
    end
    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_we;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [1:0]        r_lo;
    logic [31:0]       r_wdata;
    logic [31:0]       r_merged;
    logic [31:0]       r_rdata;
    logic              r_mis;
    logic [ADDR_W-1:0] r_mem_a;
    logic              w_accept;
    logic              w_mis;
    logic              w_sw;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;
    assign w_accept = bus.req_valid && r_state == ST_IDLE;
    assign w_mis    = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign w_sw     = r_we && r_size == SZ_WORD;
    lsu_byte_lane u_lane (
        .i_size    (r_size),
        .i_unsigned(r_uns),
        .i_addr_lo (r_lo),
        .i_rd      (bus.mem_rd),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = w_accept ? (w_mis ? ST_RESP : ST_ACCESS) : ST_IDLE;
            ST_ACCESS:   w_next = (r_we && !w_sw) ? ST_MERGE_WR : ST_RESP;
            ST_MERGE_WR: w_next = ST_RESP;
            default:     w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_uns    <= 1'b0;
            r_size   <= 2'b00;
            r_lo     <= 2'b00;
            r_wdata  <= '0;
            r_merged <= '0;
            r_rdata  <= '0;
            r_mis    <= 1'b0;
            r_mem_a  <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_size  <= bus.req_size;
                r_lo    <= bus.req_addr[1:0];
                r_wdata <= bus.req_wdata;
                if (w_mis) begin
                    r_mis   <= 1'b1;
                    r_rdata <= '0;
                end else begin
                    r_mem_a <= {2'b00, bus.req_addr[ADDR_W-1:2]};
                end
            end
            if (r_state == ST_ACCESS) r_merged <= w_merged;
            // response registers change only on the edge entering RESP so they hold otherwise
            if (r_state != ST_IDLE && w_next == ST_RESP) begin
                r_mis   <= 1'b0;
                r_rdata <= r_we ? 32'h0 : w_load;
            end
        end
    end
    assign bus.req_ready      = r_state == ST_IDLE;
    assign bus.rsp_valid      = r_state == ST_RESP;
    assign bus.rsp_rdata      = r_rdata;
    assign bus.rsp_misaligned = r_mis;
    assign bus.mem_a          = r_mem_a;
    assign bus.mem_we         = (r_state == ST_ACCESS && w_sw) || r_state == ST_MERGE_WR;
    assign bus.mem_wd         = (r_state == ST_ACCESS) ? r_wdata : r_merged;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a 1024-word comb-read/sync-write memory
module tb_load_store_unit;
    import mips_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    load_store_unit_if #(.ADDR_W(32)) bus();
    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [31:0] mem [0:1023];
    assign bus.mem_rd = mem[bus.mem_a[9:0]];
    always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_a[9:0]] <= bus.mem_wd;
    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) we_cnt++;
        if (bus.rsp_valid === 1'b1) rsp_cnt++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
    endtask
    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_mis, input int exp_we,
                          input logic [31:0] exp_wd);
        int lat;
        int we0;
        logic [31:0] wd_seen;
        wd_seen = 32'h0;
        we0 = we_cnt;
        drive(we, size, uns, addr, wdata);
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 8) begin
            if (bus.mem_we === 1'b1) wd_seen = bus.mem_wd;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, " misaligned"}, {31'h0, bus.rsp_misaligned}, {31'h0, exp_mis});
        tick();
        chk({tag, " we cycles"}, we_cnt - we0, exp_we);
        chk({tag, " ready after"}, {31'h0, bus.req_ready}, 32'h1);
        if (exp_we != 0) chk({tag, " mem_wd"}, wd_seen, exp_wd);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
    initial begin
        int r0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        rst = 1'b1;
        tick();
        chk("rst ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst rdata", bus.rsp_rdata, 32'h0);
        chk("rst misaligned", {31'h0, bus.rsp_misaligned}, 32'h0);
        chk("rst mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("rst mem_a", bus.mem_a, 32'h0);
        chk("rst mem_wd", bus.mem_wd, 32'h0);
        rst = 1'b0;
        tick();
        drive(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h0F0F0F0F);
        tick();
        bus.req_valid = 1'b0;
        chk("sw mem_a", bus.mem_a, 32'h2);
        chk("sw mem_we", {31'h0, bus.mem_we}, 32'h1);
        chk("sw mem_wd", bus.mem_wd, 32'h0F0F0F0F);
        chk("sw busy", {31'h0, bus.req_ready}, 32'h0);
        tick();
        chk("sw rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
        chk("sw misaligned", {31'h0, bus.rsp_misaligned}, 32'h0);
        chk("sw mem", mem[2], 32'h0F0F0F0F);
        tick();
        chk("sw rsp end", {31'h0, bus.rsp_valid}, 32'h0);
        do_req("sw pre", 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h123480F0, 2, 32'h0, 1'b0, 1, 32'h123480F0);
        do_req("lb", 1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 32'h0);
        do_req("lbu", 1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0, 2, 32'h00000080, 1'b0, 0, 32'h0);
        do_req("lh", 1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, 2, 32'h00001234, 1'b0, 0, 32'h0);
        do_req("lh low", 1'b0, SZ_HALF, 1'b0, 32'h08, 32'h0, 2, 32'hFFFF80F0, 1'b0, 0, 32'h0);
        do_req("lhu low", 1'b0, SZ_HALF, 1'b1, 32'h08, 32'h0, 2, 32'h000080F0, 1'b0, 0, 32'h0);
        do_req("lw", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 2, 32'h123480F0, 1'b0, 0, 32'h0);
        do_req("sw restore", 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h0F0F0F0F, 2, 32'h0, 1'b0, 1, 32'h0F0F0F0F);
        do_req("sb", 1'b1, SZ_BYTE, 1'b0, 32'h0B, 32'h000000AA, 3, 32'h0, 1'b0, 1, 32'hAA0F0F0F);
        chk("sb mem", mem[2], 32'hAA0F0F0F);
        do_req("sw restore2", 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h0F0F0F0F, 2, 32'h0, 1'b0, 1, 32'h0F0F0F0F);
        do_req("sh", 1'b1, SZ_HALF, 1'b0, 32'h08, 32'h0000BEEF, 3, 32'h0, 1'b0, 1, 32'h0F0FBEEF);
        do_req("sh hi", 1'b1, SZ_HALF, 1'b0, 32'h0A, 32'h00001357, 3, 32'h0, 1'b0, 1, 32'h1357BEEF);
        do_req("lw merged", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 2, 32'h1357BEEF, 1'b0, 0, 32'h0);
        do_req("lh mis", 1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        do_req("lw mis", 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        do_req("size11", 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
        do_req("sw mis", 1'b1, SZ_WORD, 1'b0, 32'h0A, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 32'h0);
        chk("mis mem", mem[2], 32'h1357BEEF);
        do_req("sw pre rst", 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h11111111, 2, 32'h0, 1'b0, 1, 32'h11111111);
        r0 = rsp_cnt;
        drive(1'b1, SZ_BYTE, 1'b0, 32'h08, 32'h00000022);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("mid mem_we", {31'h0, bus.mem_we}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("abort rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("abort ready", {31'h0, bus.req_ready}, 32'h1);
        chk("abort mem", mem[2], 32'h11111111);
        chk("abort no rsp", rsp_cnt - r0, 32'h0);
        chk("abort rdata", bus.rsp_rdata, 32'h0);
        r0 = rsp_cnt;
        drive(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
        tick();
        chk("hold accept1", {31'h0, bus.req_ready}, 32'h0);
        tick();
        chk("hold rsp1", {31'h0, bus.rsp_valid}, 32'h1);
        chk("hold rdata1", bus.rsp_rdata, 32'h11111111);
        tick();
        chk("hold idle", {31'h0, bus.req_ready}, 32'h1);
        tick();
        chk("hold accept2", {31'h0, bus.req_ready}, 32'h0);
        bus.req_valid = 1'b0;
        tick();
        chk("hold rsp2", {31'h0, bus.rsp_valid}, 32'h1);
        tick();
        tick();
        chk("hold rsp count", rsp_cnt - r0, 32'h2);
        chk("hold ready end", {31'h0, bus.req_ready}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
